// File: rtl/rle_encoder16.sv
// Run-length encoder: collapses consecutive equal 16-bit words into (value, count)
// word pairs, emitted value first then count on an avail/read port.
module rle_encoder16 #(
    parameter int MAX_RUN = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_last,
    input  logic        write,
    output logic        full,
    output logic [15:0] dout,
    output logic        avail,
    input  logic        read,
    output logic        overflow
);
    // state    | meaning
    // IDLE     | no run open, waiting for the first word of a stream
    // RUN      | run open in cur_val/cnt, accepting words
    // EMIT_VAL | presenting run value on dout
    // EMIT_CNT | presenting run count on dout
    typedef enum logic [1:0] {IDLE, RUN, EMIT_VAL, EMIT_CNT} state_t;

    localparam logic [15:0] MAX_RUN_W = 16'(MAX_RUN);

    state_t      state, state_n;
    logic [15:0] cur_val, cur_val_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] pend_val, pend_val_n;
    logic        pend_vld, pend_vld_n;
    logic        pend_last, pend_last_n;
    logic        emitting;

    assign emitting = (state == EMIT_VAL) || (state == EMIT_CNT);
    assign full     = emitting || !rst;
    assign avail    = emitting;

    always_comb begin
        dout = 16'd0;
        if (state == EMIT_VAL)
            dout = cur_val;
        else if (state == EMIT_CNT)
            dout = cnt;
    end

    always_comb begin
        state_n     = state;
        cur_val_n   = cur_val;
        cnt_n       = cnt;
        pend_val_n  = pend_val;
        pend_vld_n  = pend_vld;
        pend_last_n = pend_last;
        case (state)
            IDLE: begin
                if (write) begin
                    cur_val_n = din;
                    cnt_n     = 16'd1;
                    state_n   = din_last ? EMIT_VAL : RUN;
                end
            end
            RUN: begin
                if (write) begin
                    if (din == cur_val && cnt < MAX_RUN_W) begin
                        cnt_n   = cnt + 16'd1;
                        state_n = din_last ? EMIT_VAL : RUN;
                    end else begin
                        // the terminating word waits in the slot while the run drains
                        pend_val_n  = din;
                        pend_vld_n  = 1'b1;
                        pend_last_n = din_last;
                        state_n     = EMIT_VAL;
                    end
                end
            end
            EMIT_VAL: begin
                if (read)
                    state_n = EMIT_CNT;
            end
            EMIT_CNT: begin
                if (read) begin
                    if (pend_vld) begin
                        cur_val_n  = pend_val;
                        cnt_n      = 16'd1;
                        pend_vld_n = 1'b0;
                        state_n    = pend_last ? EMIT_VAL : RUN;
                    end else begin
                        cnt_n   = 16'd0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_val   <= 16'd0;
            cnt       <= 16'd0;
            pend_val  <= 16'd0;
            pend_vld  <= 1'b0;
            pend_last <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cur_val   <= cur_val_n;
            cnt       <= cnt_n;
            pend_val  <= pend_val_n;
            pend_vld  <= pend_vld_n;
            pend_last <= pend_last_n;
            if (write && emitting)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rle_encoder16.sv
// Directed bench for rle_encoder16: default MAX_RUN instance plus a MAX_RUN=4 instance.
module tb_rle_encoder16;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = 16'd0;
    logic        din_last = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        sel_b = 1'b0;

    logic        write_a, write_b;
    logic        full_a, avail_a, overflow_a;
    logic        full_b, avail_b, overflow_b;
    logic [15:0] dout_a, dout_b;
    logic        full_sel;

    int total = 0;
    int bad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_q[$];

    assign write_a  = write & ~sel_b;
    assign write_b  = write & sel_b;
    assign full_sel = sel_b ? full_b : full_a;

    always #5 clk = ~clk;

    rle_encoder16 u_a (
        .clk(clk), .rst(rst), .din(din), .din_last(din_last), .write(write_a),
        .full(full_a), .dout(dout_a), .avail(avail_a), .read(read), .overflow(overflow_a)
    );

    rle_encoder16 #(.MAX_RUN(4)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_last(din_last), .write(write_b),
        .full(full_b), .dout(dout_b), .avail(avail_b), .read(read), .overflow(overflow_b)
    );

    // inputs change only just after posedge, so a word seen here is popped on the next edge
    always @(negedge clk) begin
        if (avail_a && read) qa.push_back(dout_a);
        if (avail_b && read) qb.push_back(dout_b);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input logic l);
        int g = 0;
        while (full_sel !== 1'b0 && g < 100) begin
            step();
            g++;
        end
        check("push_wait", 16'(g < 100), 16'd1);
        din = v;
        din_last = l;
        write = 1'b1;
        step();
        write = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input bit on_b);
        int g = 0;
        int n;
        while ((on_b ? qb.size() : qa.size()) < exp_q.size() && g < 200) begin
            step();
            g++;
        end
        check({tag, "_wait"}, 16'(g < 200), 16'd1);
        repeat (3) step();
        n = on_b ? qb.size() : qa.size();
        check({tag, "_len"}, 16'(n), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n)
                check($sformatf("%s_w%0d", tag, i), on_b ? qb[i] : qa[i], exp_q[i]);
        end
        qa.delete();
        qb.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset state
        #2;
        check("rst_avail", 16'(avail_a), 16'd0);
        check("rst_full", 16'(full_a), 16'd1);
        check("rst_ovf", 16'(overflow_a), 16'd0);
        check("rst_dout", dout_a, 16'd0);
        step();
        rst = 1'b1;
        step();
        check("idle_full", 16'(full_a), 16'd0);

        // single run of five, last on the fifth
        read = 1'b1;
        for (int i = 0; i < 4; i++) push(16'hABCD, 1'b0);
        push(16'hABCD, 1'b1);
        check("lat_avail", 16'(avail_a), 16'd1);
        check("lat_dout", dout_a, 16'hABCD);
        exp_q = '{16'hABCD, 16'h0005};
        expect_seq("run5", 1'b0);
        check("run5_idle_full", 16'(full_a), 16'd0);
        check("run5_idle_avail", 16'(avail_a), 16'd0);

        // mixed runs
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b1);
        exp_q = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0001};
        expect_seq("mixed", 1'b0);

        // run split at MAX_RUN=4
        sel_b = 1'b1;
        for (int i = 0; i < 5; i++) push(16'h1234, 1'b0);
        push(16'h1234, 1'b1);
        exp_q = '{16'h1234, 16'h0004, 16'h1234, 16'h0002};
        expect_seq("maxrun", 1'b1);
        sel_b = 1'b0;

        // backpressure with a pending word
        read = 1'b0;
        push(16'h0A0A, 1'b0);
        push(16'h0B0B, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("bp_avail", 16'(avail_a), 16'd1);
            check("bp_dout", dout_a, 16'h0A0A);
            check("bp_full", 16'(full_a), 16'd1);
            step();
        end
        read = 1'b1;
        push(16'h0C0C, 1'b1);
        exp_q = '{16'h0A0A, 16'h0001, 16'h0B0B, 16'h0001, 16'h0C0C, 16'h0001};
        expect_seq("bp", 1'b0);
        check("bp_ovf", 16'(overflow_a), 16'd0);

        // write while full is dropped and flagged
        read = 1'b0;
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        check("ovf_full", 16'(full_a), 16'd1);
        din = 16'h9999;
        write = 1'b1;
        step();
        write = 1'b0;
        check("ovf_set", 16'(overflow_a), 16'd1);
        read = 1'b1;
        push(16'h3333, 1'b1);
        exp_q = '{16'h1111, 16'h0001, 16'h2222, 16'h0001, 16'h3333, 16'h0001};
        expect_seq("ovf", 1'b0);
        check("ovf_sticky", 16'(overflow_a), 16'd1);

        // reset mid-run discards the partial run
        for (int i = 0; i < 3; i++) push(16'h5555, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_avail", 16'(avail_a), 16'd0);
        check("mid_rst_full", 16'(full_a), 16'd1);
        check("mid_rst_ovf", 16'(overflow_a), 16'd0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_full", 16'(full_a), 16'd0);
        qa.delete();
        push(16'h7777, 1'b1);
        exp_q = '{16'h7777, 16'h0001};
        expect_seq("post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
